// File: rtl/alu_pkg.sv
// Opcode encoding shared by decode, the operand stage and the ALU.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    A_NOP = 5'h00,
    A_ADD = 5'h01,
    A_SUB = 5'h02,
    A_AND = 5'h03,
    A_OR  = 5'h04,
    A_XOR = 5'h05,
    A_NOR = 5'h06
  } alu_op_e;

  // Which source an operand was resolved from; handy when probing the mux.
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd.sv
// Operand resolution for one source register: $0, then the instruction
// currently in EX, then the writeback stage, then the register file.
module operand_fwd
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output fwd_sel_e          sel
);

  // Select the youngest producer; EX is younger than WB so it wins.
  always_comb begin
    sel = FWD_RF;
    if (addr == '0) begin
      sel = FWD_ZERO;
    end else if (ex_valid && (ex_rd == addr)) begin
      sel = FWD_EX;
    end else if (wb_we && (wb_addr == addr)) begin
      sel = FWD_WB;
    end
  end

  // Route the selected source onto the operand.
  always_comb begin
    data = rf_data;
    unique case (sel)
      FWD_ZERO: data = '0;
      FWD_EX:   data = ex_data;
      FWD_WB:   data = wb_data;
      FWD_RF:   data = rf_data;
      default:  data = rf_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: accepts decoded instructions, resolves operands
// through EX/WB forwarding at capture and holds them for the ALU.
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [ALU_OP_W-1:0] dec_alu_op,
  input  logic [REG_AW-1:0]   dec_rs_addr,
  input  logic [REG_AW-1:0]   dec_rt_addr,
  input  logic [REG_AW-1:0]   dec_rd_addr,
  input  logic [DATA_W-1:0]   dec_rs_data,
  input  logic [DATA_W-1:0]   dec_rt_data,
  input  logic [DATA_W-1:0]   dec_imm,
  input  logic                dec_use_imm,
  input  logic                flush,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic              capture;
  logic              stalled;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  fwd_sel_e          sel_a;
  fwd_sel_e          sel_b;

  assign dec_ready = !ex_valid || ex_ready;
  assign capture   = dec_valid && dec_ready && !flush;
  assign stalled   = ex_valid && !ex_ready;

  // EX forwarding is safe here: capture implies the held instruction leaves
  // this cycle, so alu_out is its final result.
  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr     (dec_rs_addr),
    .rf_data  (dec_rs_data),
    .ex_valid (ex_valid),
    .ex_rd    (ex_rd),
    .ex_data  (alu_out),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .data     (fwd_a),
    .sel      (sel_a)
  );

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr     (dec_rt_addr),
    .rf_data  (dec_rt_data),
    .ex_valid (ex_valid),
    .ex_rd    (ex_rd),
    .ex_data  (alu_out),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .data     (fwd_b),
    .sel      (sel_b)
  );

  // Held instruction register: reset > flush > capture > drain > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      alu_op   <= A_NOP;
      alu_a    <= '0;
      alu_b    <= '0;
      ex_rd    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      alu_op   <= A_NOP;
    end else if (capture) begin
      ex_valid <= 1'b1;
      alu_op   <= dec_alu_op;
      alu_a    <= fwd_a;
      alu_b    <= dec_use_imm ? dec_imm : fwd_b;
      ex_rd    <= dec_rd_addr;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
      alu_op   <= A_NOP;
    end
  end

  // Saturating count of cycles the held instruction was blocked downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed vector bench for ex_operand_stage.
module tb_ex_operand_stage;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic          dec_ready;
  logic [4:0]    dec_alu_op;
  logic [AW-1:0] dec_rs_addr, dec_rt_addr, dec_rd_addr;
  logic [DW-1:0] dec_rs_data, dec_rt_data, dec_imm;
  logic          dec_use_imm;
  logic          flush;
  logic [DW-1:0] alu_out;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_ready;
  logic          ex_valid;
  logic [DW-1:0] alu_a, alu_b;
  logic [4:0]    alu_op;
  logic [AW-1:0] ex_rd;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_alu_op(dec_alu_op),
    .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr), .dec_rd_addr(dec_rd_addr),
    .dec_rs_data(dec_rs_data), .dec_rt_data(dec_rt_data), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .flush(flush), .alu_out(alu_out),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_rd(ex_rd), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rst, dv, ui, fl, wbwe, exr;
    logic [4:0]  op, rs, rt, rd, wba;
    logic [31:0] rsd, rtd, imm, aout, wbd;
    logic        e_rdy, e_v;
    logic [4:0]  e_op, e_rd;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic dv, logic [4:0] op, logic [4:0] rs, logic [31:0] rsd,
    logic [4:0] rt, logic [31:0] rtd, logic [4:0] rd, logic ui, logic [31:0] imm,
    logic fl, logic [31:0] aout, logic wbwe, logic [4:0] wba, logic [31:0] wbd,
    logic exr,
    logic e_rdy, logic e_v, logic [4:0] e_op, logic [31:0] e_a, logic [31:0] e_b,
    logic [4:0] e_rd, logic [3:0] e_cnt);
    vec_t v;
    v.rst = r; v.dv = dv; v.op = op; v.rs = rs; v.rsd = rsd; v.rt = rt; v.rtd = rtd;
    v.rd = rd; v.ui = ui; v.imm = imm; v.fl = fl; v.aout = aout; v.wbwe = wbwe;
    v.wba = wba; v.wbd = wbd; v.exr = exr; v.e_rdy = e_rdy; v.e_v = e_v;
    v.e_op = e_op; v.e_a = e_a; v.e_b = e_b; v.e_rd = e_rd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; dec_valid = v.dv; dec_alu_op = v.op;
    dec_rs_addr = v.rs; dec_rs_data = v.rsd; dec_rt_addr = v.rt; dec_rt_data = v.rtd;
    dec_rd_addr = v.rd; dec_use_imm = v.ui; dec_imm = v.imm; flush = v.fl;
    alu_out = v.aout; wb_we = v.wbwe; wb_addr = v.wba; wb_data = v.wbd;
    ex_ready = v.exr;
  endtask

  task automatic chk_outs(string tag, logic v, logic [4:0] op, logic [31:0] a,
                          logic [31:0] b, logic [4:0] rd, logic [3:0] cnt);
    chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, v});
    chk({tag, " alu_op"}, {27'd0, alu_op}, {27'd0, op});
    chk({tag, " alu_a"}, alu_a, a);
    chk({tag, " alu_b"}, alu_b, b);
    chk({tag, " ex_rd"}, {27'd0, ex_rd}, {27'd0, rd});
    chk({tag, " stall_cnt"}, {28'd0, stall_cnt}, {28'd0, cnt});
  endtask

  initial begin
    // rst dv op rs rsd rt rtd rd ui imm fl aout wbwe wba wbd exr | rdy v op a b rd cnt
    vecs.push_back(mk(0,0,5'h00,0,0,0,0,0,0,0,0,0,0,0,0,1,          1,0,5'h00,0,0,0,0));
    vecs.push_back(mk(0,1,5'h01,1,5,2,7,3,0,0,0,0,0,0,0,1,          1,1,5'h01,5,7,3,0));
    vecs.push_back(mk(0,1,5'h02,1,5,2,7,4,0,0,0,0,0,0,0,1,          1,1,5'h02,5,7,4,0));
    vecs.push_back(mk(0,1,5'h01,4,0,2,7,5,0,0,0,12,1,4,9,1,         1,1,5'h01,12,7,5,0));
    vecs.push_back(mk(0,1,5'h03,0,32'hFF,2,7,6,0,0,0,32'hAAAA,1,2,32'h55,1, 1,1,5'h03,0,32'h55,6,0));
    vecs.push_back(mk(0,1,5'h01,1,5,6,7,7,1,32'hFFFF_FFFE,0,32'h1234,1,6,32'h66,1,
                      1,1,5'h01,5,32'hFFFF_FFFE,7,0));
    vecs.push_back(mk(0,1,5'h04,1,1,2,2,8,0,0,0,32'h11,0,0,0,0,     0,1,5'h01,5,32'hFFFF_FFFE,7,1));
    vecs.push_back(mk(0,1,5'h04,1,1,2,2,8,0,0,0,32'h22,0,0,0,0,     0,1,5'h01,5,32'hFFFF_FFFE,7,2));
    vecs.push_back(mk(0,1,5'h04,1,1,2,2,8,0,0,0,32'h33,0,0,0,0,     0,1,5'h01,5,32'hFFFF_FFFE,7,3));
    vecs.push_back(mk(0,1,5'h04,1,32'h10,2,32'h20,8,0,0,0,0,0,0,0,1, 1,1,5'h04,32'h10,32'h20,8,3));
    vecs.push_back(mk(0,0,5'h00,0,0,0,0,0,0,0,0,0,0,0,0,1,          1,0,5'h00,32'h10,32'h20,8,3));
    vecs.push_back(mk(0,1,5'h05,3,3,4,4,9,0,0,0,0,0,0,0,1,          1,1,5'h05,3,4,9,3));
    vecs.push_back(mk(0,1,5'h06,1,1,2,2,10,0,0,1,0,0,0,0,0,         0,0,5'h00,3,4,9,4));
    vecs.push_back(mk(0,1,5'h06,1,1,2,2,10,0,0,1,0,0,0,0,1,         1,0,5'h00,3,4,9,4));
    vecs.push_back(mk(0,1,5'h1F,9,32'hABC,12,32'hDEF,11,0,0,0,32'h777,1,9,32'h999,1,
                      1,1,5'h1F,32'h999,32'hDEF,11,4));
    vecs.push_back(mk(0,0,5'h00,0,0,0,0,0,0,0,0,0,0,0,0,0,          0,1,5'h1F,32'h999,32'hDEF,11,5));
    vecs.push_back(mk(1,1,5'h02,1,1,2,2,12,0,0,0,0,0,0,0,0,         0,0,5'h00,0,0,0,0));

    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 5'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset dec_ready", {31'd0, dec_ready}, 32'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d dec_ready", i), {31'd0, dec_ready}, {31'd0, vecs[i].e_rdy});
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_op, vecs[i].e_a,
               vecs[i].e_b, vecs[i].e_rd, vecs[i].e_cnt);
    end

    // Long stall drives the counter into saturation, then a drain must not wrap it.
    @(negedge clk);
    drive(mk(0,1,5'h01,1,32'h21,2,32'h42,13,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    @(negedge clk);
    dec_valid = 1'b0;
    ex_ready  = 1'b0;
    repeat (20) @(negedge clk);
    chk_outs("saturate", 1'b1, 5'h01, 32'h21, 32'h42, 13, 4'hF);
    ex_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("drain after saturate", 1'b0, 5'h00, 32'h21, 32'h42, 13, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register that feeds the combinational ALU. Accepts a decoded instruction from the decode stage under a valid/ready handshake, resolves both operands through EX and WB forwarding, and holds `alu_a`, `alu_b`, `alu_op` and the destination register stable for the ALU and the downstream writeback register. Supports stall, flush and a saturating stall counter for performance debug.

## Interface
- `DATA_W`, 32: operand/result width.
- `REG_AW`, 5: register address width.
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `dec_valid`  in  1  decode offers an instruction.
- `dec_ready`  out  1  stage can accept this cycle.
- `dec_alu_op`  in  5  ALU opcode (shared package encoding).
- `dec_rs_addr`, `dec_rt_addr`, `dec_rd_addr`  in  REG_AW  source/destination registers.
- `dec_rs_data`, `dec_rt_data`  in  DATA_W  register-file read data.
- `dec_imm`  in  DATA_W  immediate, already extended by decode.
- `dec_use_imm`  in  1  operand B = immediate.
- `flush`  in  1  discard held and incoming instruction.
- `alu_out`  in  DATA_W  ALU result for the currently held instruction (EX forward source).
- `wb_we`, `wb_addr`, `wb_data`  in  1/REG_AW/DATA_W  writeback-stage write (WB forward source).
- `ex_ready`  in  1  downstream accepts held instruction.
- `ex_valid`  out  1  held instruction valid.
- `alu_a`, `alu_b`  out  DATA_W  operands to ALU.
- `alu_op`  out  5  opcode to ALU.
- `ex_rd`  out  REG_AW  destination of held instruction.
- `stall_cnt`  out  CNT_W  cycles with `ex_valid && !ex_ready`, saturating.

## Operation
- `dec_ready = !ex_valid || ex_ready` (combinational; independent of `dec_valid`).
- Capture: `dec_valid && dec_ready && !flush` → next cycle `ex_valid=1`, outputs load resolved operands.
- Drain: `ex_valid && ex_ready` with no capture → next cycle `ex_valid=0`.
- Stall: `ex_valid && !ex_ready` → all outputs hold unchanged; `stall_cnt` increments, saturates at all-ones.
- Flush: next cycle `ex_valid=0`, `alu_op=A_NOP`; incoming instruction dropped even if `dec_valid`. Flush beats capture; `rst` beats everything.
- When `ex_valid=0`, `alu_op=A_NOP` (5'h00); `alu_a`, `alu_b`, `ex_rd` retain their last values (don't-care).
- Operand resolution at capture, per source (rs→`alu_a`, rt→`alu_b` unless `dec_use_imm`), priority order:
  1. addr == 0 → 0.
  2. `ex_valid && ex_rd == addr` → `alu_out` (the held instruction is leaving this cycle, since capture implies `ex_ready`).
  3. `wb_we && wb_addr == addr` → `wb_data`.
  4. else register-file data.
- `dec_use_imm=1` → `alu_b = dec_imm`; rt forwarding is ignored.
- Operands are final once captured; no re-forwarding while stalled.
- Opcode passes through unmodified; undefined codes are passed to the ALU as-is.

## Timing
- Reset (sync): `ex_valid=0`, `alu_op=A_NOP`, `alu_a=0`, `alu_b=0`, `ex_rd=0`, `stall_cnt=0`. `dec_ready=1` in the first cycle after reset.
- Latency: 1 cycle from capture edge to valid outputs. Throughput: 1 instruction/cycle when `ex_ready` is held high.
- `rst` asserted mid-stall: the instruction is discarded and `stall_cnt` clears.
- Simultaneous drain and capture: the new instruction replaces the old with no bubble.
- Simultaneous `flush` and `ex_ready=0`: flush wins and `ex_valid` drops.

## Structure
- Shared package `alu_pkg`: opcode width (5) and constants `A_NOP`=00, `A_ADD`=01, `A_SUB`=02, `A_AND`=03, `A_OR`=04, `A_XOR`=05, `A_NOR`=06. Used by the ALU, decode and this block.
- Sub-module `operand_fwd`: combinational 4-way priority mux (zero / EX / WB / regfile). Instantiated twice (rs, rt). All state lives in `ex_operand_stage`.

## Test plan
- Reset then idle: `ex_valid=0`, `alu_op=00`, `dec_ready=1`, `stall_cnt=0`.
- Back-to-back, no hazards: `add rd=3, rs=1(5), rt=2(7)`, then `sub rd=4, rs=1, rt=2`, with `ex_ready=1` → consecutive cycles show `alu_op=01`, a=5, b=7, then `alu_op=02`, a=5, b=7.
- EX forward: held `rd=3` with `alu_out=12`; capture `rs=3` with stale regfile data 0 and `wb_we=1`, `wb_addr=3`, `wb_data=9` → `alu_a=12`.
- WB forward and $0: `wb_we=1`, `wb_addr=2`, `wb_data=0x55`; capture `rt=2`, `rs=0` with `dec_rs_data=0xFF` → `alu_b=0x55`, `alu_a=0`. With `dec_use_imm=1`, `dec_imm=0xFFFF_FFFE` → `alu_b=0xFFFF_FFFE`.
- Stall: `ex_ready=0` for 3 cycles with `dec_valid=1` → `dec_ready=0`, outputs frozen, `stall_cnt=3`. Then `ex_ready=1` → the new instruction loads the next cycle.
- Flush/reset priority: `flush=1` with `dec_valid=1` → next `ex_valid=0`, `alu_op=00`. `rst` during a stall → all outputs at reset values the next cycle.
